serial_adder: RTL and testbench

//   Multi-cycle, parametrised successor to the single-bit full adder.

---
 rtl/serial_adder.sv | 109 ++++++++++
 tb/tb_serial_adder.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial adder: adds two WIDTH-bit operands plus carry-in, BPC bits per clock,
// through a registered carry, with a start/busy/done handshake.
module serial_adder #(
  parameter int WIDTH = 8,
  parameter int BPC   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int N  = WIDTH / BPC;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  if (BPC < 1 || (WIDTH % BPC) != 0) begin : g_bad_bpc
    $fatal(1, "serial_adder: BPC must divide WIDTH");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] part;
  logic [WIDTH-1:0] part_next;
  logic             cr;
  logic [CW-1:0]    count;
  logic [BPC:0]     slice;
  logic             msb_cin;

  assign state_dbg = state;

  // One BPC-bit slice of the sum; the extra top bit is the carry to the next slice.
  assign slice = {1'b0, op_a[BPC-1:0]} + {1'b0, op_b[BPC-1:0]} + {{BPC{1'b0}}, cr};
  // Carry into the top bit of the slice, recovered from its sum bit and operand bits.
  assign msb_cin = op_a[BPC-1] ^ op_b[BPC-1] ^ slice[BPC-1];

  if (BPC == WIDTH) begin : g_full
    assign part_next = slice[BPC-1:0];
  end else begin : g_shift
    assign part_next = {slice[BPC-1:0], part[WIDTH-1:BPC]};
  end

  // Handshake: start is accepted only in IDLE or DONE and samples a/b/c_in on
  // that edge; busy is high for the N RUN cycles; done pulses for one cycle when
  // sum/carry/overflow take their new value, and those outputs hold until the next done.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      sum      <= '0;
      carry    <= 1'b0;
      overflow <= 1'b0;
      op_a     <= '0;
      op_b     <= '0;
      part     <= '0;
      cr       <= 1'b0;
      count    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          if (start) begin
            op_a  <= a;
            op_b  <= b;
            cr    <= c_in;
            count <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
        RUN: begin
          op_a  <= op_a >> BPC;
          op_b  <= op_b >> BPC;
          part  <= part_next;
          cr    <= slice[BPC];
          count <= count + 1'b1;
          if (count == LAST) begin
            sum      <= part_next;
            carry    <= slice[BPC];
            overflow <= msb_cin ^ slice[BPC];
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder: three instances (8/1, 4/2, 8/8) checked every cycle
// against a latency-counter arithmetic model, plus hand-computed results.
module tb_serial_adder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start_v[3];
  logic [7:0] a_v[3];
  logic [7:0] b_v[3];
  logic       cin_v[3];
  logic       busy_o[3];
  logic       done_o[3];
  logic       carry_o[3];
  logic       ovf_o[3];
  logic [7:0] sum0;
  logic [3:0] sum1;
  logic [7:0] sum2;
  logic [1:0] st0, st1, st2;

  int checks = 0;
  int errors = 0;
  int done_cnt[3];
  bit chk_en = 1'b0;

  serial_adder #(.WIDTH(8), .BPC(1)) u_w8b1 (
    .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0]), .b(b_v[0]), .c_in(cin_v[0]),
    .busy(busy_o[0]), .done(done_o[0]), .sum(sum0), .carry(carry_o[0]),
    .overflow(ovf_o[0]), .state_dbg(st0)
  );

  serial_adder #(.WIDTH(4), .BPC(2)) u_w4b2 (
    .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][3:0]), .b(b_v[1][3:0]), .c_in(cin_v[1]),
    .busy(busy_o[1]), .done(done_o[1]), .sum(sum1), .carry(carry_o[1]),
    .overflow(ovf_o[1]), .state_dbg(st1)
  );

  serial_adder #(.WIDTH(8), .BPC(8)) u_w8b8 (
    .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2]), .b(b_v[2]), .c_in(cin_v[2]),
    .busy(busy_o[2]), .done(done_o[2]), .sum(sum2), .carry(carry_o[2]),
    .overflow(ovf_o[2]), .state_dbg(st2)
  );

  function automatic int w_of(input int i);
    return (i == 1) ? 4 : 8;
  endfunction

  function automatic int n_of(input int i);
    return (i == 0) ? 8 : ((i == 1) ? 2 : 1);
  endfunction

  function automatic logic [7:0] get_sum(input int i);
    case (i)
      0:       return sum0;
      1:       return {4'h0, sum1};
      default: return sum2;
    endcase
  endfunction

  // Reference: {overflow, carry, sum} from integer addition and sign rules.
  function automatic logic [9:0] ref_add(input int w, input logic [7:0] a, input logic [7:0] b,
                                         input logic ci);
    int mask, av, bv, full, s, c, sa, sb, ss, ov;
    mask = (1 << w) - 1;
    av   = int'(a) & mask;
    bv   = int'(b) & mask;
    full = av + bv + int'(ci);
    s    = full & mask;
    c    = (full >> w) & 1;
    sa   = (av >> (w - 1)) & 1;
    sb   = (bv >> (w - 1)) & 1;
    ss   = (s >> (w - 1)) & 1;
    ov   = (sa == sb && ss != sa) ? 1 : 0;
    return {1'(ov), 1'(c), 8'(s)};
  endfunction

  // Model: an accepted start schedules its result N edges later.
  int         remain[3];
  logic [9:0] pend[3];
  logic [9:0] held[3];
  logic       ex_busy[3];
  logic       ex_done[3];

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        remain[i]  = 0;
        held[i]    = '0;
        ex_busy[i] = 1'b0;
        ex_done[i] = 1'b0;
      end else begin
        ex_done[i] = 1'b0;
        if (remain[i] > 0) begin
          remain[i] = remain[i] - 1;
          if (remain[i] == 0) begin
            held[i]    = pend[i];
            ex_done[i] = 1'b1;
            ex_busy[i] = 1'b0;
          end
        end else if (start_v[i]) begin
          pend[i]    = ref_add(w_of(i), a_v[i], b_v[i], cin_v[i]);
          remain[i]  = n_of(i);
          ex_busy[i] = 1'b1;
        end
      end
    end
    if (rst) chk_en = 1'b1;
  end

  task automatic chk(input string name, input int i, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %h expected %h at %0t", name, i, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        chk("busy", i, {7'b0, busy_o[i]}, {7'b0, ex_busy[i]});
        chk("done", i, {7'b0, done_o[i]}, {7'b0, ex_done[i]});
        chk("sum", i, get_sum(i), held[i][7:0]);
        chk("carry", i, {7'b0, carry_o[i]}, {7'b0, held[i][8]});
        chk("overflow", i, {7'b0, ovf_o[i]}, {7'b0, held[i][9]});
        if (done_o[i] === 1'b1) done_cnt[i]++;
      end
    end
  end

  task automatic lit(input string name, input int i, input logic [7:0] s, input logic c,
                     input logic o);
    chk({name, "_sum"}, i, get_sum(i), s);
    chk({name, "_carry"}, i, {7'b0, carry_o[i]}, {7'b0, c});
    chk({name, "_ovf"}, i, {7'b0, ovf_o[i]}, {7'b0, o});
  endtask

  // Starts at posedge+1, leaves at posedge+1 after the accepting edge.
  task automatic launch(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci);
    start_v[i] = 1'b1;
    a_v[i]     = a;
    b_v[i]     = b;
    cin_v[i]   = ci;
    @(posedge clk);
    #1;
    start_v[i] = 1'b0;
    a_v[i]     = ~a;
    b_v[i]     = ~b;
    cin_v[i]   = ~ci;
  endtask

  // Returns at the negedge where done is seen.
  task automatic wait_done(input string name, input int i, input int budget);
    bit found;
    found = 1'b0;
    for (int k = 0; k < budget && !found; k++) begin
      @(negedge clk);
      if (done_o[i] === 1'b1) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL %s_timeout[%0d] done not seen within %0d cycles", name, i, budget);
    end
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i]  = 1'b0;
      a_v[i]      = '0;
      b_v[i]      = '0;
      cin_v[i]    = 1'b0;
      done_cnt[i] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_busy", 0, {7'b0, busy_o[0]}, 8'h00);
    chk("rst_done", 0, {7'b0, done_o[0]}, 8'h00);
    lit("rst", 0, 8'h00, 1'b0, 1'b0);
    next_edge();

    // T1
    launch(0, 8'h5A, 8'h3C, 1'b0);
    wait_done("t1", 0, 12);
    lit("t1", 0, 8'h96, 1'b0, 1'b1);
    next_edge();

    // T2
    launch(0, 8'hFF, 8'h01, 1'b0);
    wait_done("t2a", 0, 12);
    lit("t2a", 0, 8'h00, 1'b1, 1'b0);
    next_edge();
    launch(0, 8'h80, 8'h80, 1'b1);
    wait_done("t2b", 0, 12);
    lit("t2b", 0, 8'h01, 1'b1, 1'b1);
    next_edge();

    // T3: start during RUN is ignored
    launch(0, 8'h12, 8'h34, 1'b0);
    repeat (2) next_edge();
    start_v[0] = 1'b1;
    a_v[0]     = 8'h11;
    b_v[0]     = 8'h22;
    next_edge();
    start_v[0] = 1'b0;
    wait_done("t3", 0, 12);
    lit("t3", 0, 8'h46, 1'b0, 1'b0);
    repeat (12) next_edge();

    // T4: reset mid-operation
    launch(0, 8'h5A, 8'h3C, 1'b0);
    repeat (3) next_edge();
    rst = 1'b1;
    next_edge();
    rst = 1'b0;
    @(negedge clk);
    chk("t4_busy", 0, {7'b0, busy_o[0]}, 8'h00);
    chk("t4_done", 0, {7'b0, done_o[0]}, 8'h00);
    lit("t4_rst", 0, 8'h00, 1'b0, 1'b0);
    repeat (12) next_edge();
    launch(0, 8'hFF, 8'h01, 1'b0);
    wait_done("t4", 0, 12);
    lit("t4", 0, 8'h00, 1'b1, 1'b0);
    next_edge();

    // T5: exhaustive 4-bit, start held high
    for (int av = 0; av < 16; av++) begin
      for (int bv = 0; bv < 16; bv++) begin
        for (int cv = 0; cv < 2; cv++) begin
          start_v[1] = 1'b1;
          a_v[1]     = 8'(av);
          b_v[1]     = 8'(bv);
          cin_v[1]   = 1'(cv);
          repeat (3) next_edge();
        end
      end
    end
    start_v[1] = 1'b0;
    wait_done("t5", 1, 4);
    lit("t5_last", 1, 8'h0F, 1'b1, 1'b0);
    next_edge();
    checks++;
    if (done_cnt[1] != 512) begin
      errors++;
      $display("FAIL t5_count done pulses %0d expected 512", done_cnt[1]);
    end

    // T6: BPC == WIDTH, done one cycle after start
    launch(2, 8'h7F, 8'h01, 1'b0);
    @(negedge clk);
    chk("t6_done_early", 2, {7'b0, done_o[2]}, 8'h00);
    @(posedge clk);
    @(negedge clk);
    chk("t6_done", 2, {7'b0, done_o[2]}, 8'h01);
    lit("t6", 2, 8'h80, 1'b0, 1'b1);
    next_edge();
    launch(2, 8'hFF, 8'hFF, 1'b1);
    wait_done("t6b", 2, 4);
    lit("t6b", 2, 8'hFF, 1'b1, 1'b0);

    repeat (3) next_edge();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
